hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Per-register scoreboard in the ID stage that produces `hazard_detected` for the pipeline controller and the IF/ID stall logic. It tracks in-flight writeback destinations with per-register countdown counters and flags read-after-write hazards against the instruction currently in ID. It also keeps a saturating stall-cycle performance counter.

## Interface
- `REG_ADDR_LEN`, default 5: register index width; the register file has 2^REG_ADDR_LEN entries.
- `PIPE_DEPTH`, default 3: cycles between the issue edge and the register file write becoming readable in ID (EXE, MEM, WB). Range 1..3; counters are 2 bits.
- `STALL_CNT_LEN`, default 16: width of the stall performance counter.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `id_valid`  input  1  valid instruction in ID.
- `id_src1`  input  REG_ADDR_LEN  first source register.
- `id_src2`  input  REG_ADDR_LEN  second source register.
- `id_src2_used`  input  1  instruction reads src2 (R-type, ST, BNE).
- `id_wb_en`  input  1  instruction writes back (WB_EN from controller).
- `id_mem_r_en`  input  1  instruction is a load.
- `id_dest`  input  REG_ADDR_LEN  destination register.
- `stall_clr`  input  1  synchronous clear of `stall_count`.
- `hazard_detected`  output  1  stall ID/IF this cycle; the controller inserts a bubble.
- `pending`  output  2^REG_ADDR_LEN  bit i set while register i's counter is non-zero.
- `stall_count`  output  STALL_CNT_LEN  saturating count of cycles with `hazard_detected`=1.

## Operation
- State: one 2-bit counter per register, plus `stall_count`. Counter 0 is hardwired to 0.
- **Issue:** issue = `id_valid` & !`hazard_detected`.
- **Load value:** on issue with `id_wb_en`=1 and `id_dest`≠0, `cnt[id_dest]` loads LOADVAL.
  - Without FORWARDING_EN: LOADVAL = PIPE_DEPTH.
  - With FORWARDING_EN: see Configuration.
- **Decrement:** every edge, each non-zero counter not being loaded decrements by 1.
- **Same-register load:** a load to a register wins over its decrement. Re-issuing to an already pending register reloads its counter; counters never accumulate.
- **Hazard:** `hazard_detected` = `id_valid` & ((`cnt[id_src1]`≠0) | (`id_src2_used` & `cnt[id_src2]`≠0)).
  - Combinational from registered counters and ID inputs.
  - Sources equal to 0 never hazard.
- **While stalled:** no issue occurs and counters keep decrementing. The stall therefore ends on its own, without a handshake.
- **Stall counter:** `stall_count` increments when `hazard_detected`=1 and holds at all-ones.
  - `stall_clr` forces it to 0 and has priority over increment.
- **Pending vector:** `pending[i]` = (`cnt[i]`≠0), from registers.
- **Reset:** asserting `rst` low clears all counters and `stall_count` immediately, including in the middle of a stall. The same cycle `pending`=0 and `hazard_detected`=0.

## Timing
- Issue edge at the end of cycle t: the dependent instruction sees counter values PIPE_DEPTH..1 in cycles t+1..t+PIPE_DEPTH, so it stalls PIPE_DEPTH cycles and proceeds in cycle t+PIPE_DEPTH+1.
- The register file is written on the edge that ends WB; ID has no bypass.
- `hazard_detected` has zero-cycle latency from ID inputs. No path from `hazard_detected` feeds back into the hazard equation itself.
- `pending` and `stall_count` update one edge after the causing event.

## Configuration
- Macro: `HAZARD_FORWARDING_EN`.
- **Defined:** the pipeline has EXE/MEM forwarding.
  - ALU writers (`id_mem_r_en`=0) load no counter.
  - Loads set LOADVAL=1, giving exactly one load-use stall cycle.
- **Undefined:** every writeback loads PIPE_DEPTH, as described above.

## Test plan
- **Reset:** hold `rst`=0 with random inputs → `pending`=0, `hazard_detected`=0, `stall_count`=0.
- **ALU RAW, no forwarding:** issue ADD R1, then next cycle ADD R2,R1,R3 → `hazard_detected` high 3 cycles, issue in the 4th, `stall_count`=3.
- **With HAZARD_FORWARDING_EN:** same ADD pair → no stall. LD R4 followed by ADD R5,R4,R4 → exactly 1 stall cycle, `pending[4]` high 1 cycle.
- **Register 0 and unused src2:**
  - Write to R0 with `id_wb_en`=1 → `pending`=0, no stall.
  - R6 pending with `id_src2`=6 and `id_src2_used`=0 → no stall.
  - ST with `id_src2_used`=1 reading R6 → stall.
- **Re-issue and reset mid-stall:**
  - Re-issue to R7 while `cnt[7]`=1 → reloads to 3.
  - Assert `rst` during a stall → `hazard_detected` drops in the same cycle, and the instruction issues after release.
- **Saturation and clear:**
  - Preload `stall_count`=0xFFFF via a long stall sequence → it holds 0xFFFF.
  - Pulse `stall_clr` during a stall → 0 on the next edge.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage bundle between the decode/controller side and hazard_scoreboard.
interface hazard_scoreboard_if #(
   parameter int unsigned REG_ADDR_LEN  = 5,
   parameter int unsigned STALL_CNT_LEN = 16
);
   logic                            id_valid;
   logic [REG_ADDR_LEN-1:0]         id_src1;
   logic [REG_ADDR_LEN-1:0]         id_src2;
   logic                            id_src2_used;
   logic                            id_wb_en;
   logic                            id_mem_r_en;
   logic [REG_ADDR_LEN-1:0]         id_dest;
   logic                            stall_clr;
   logic                            hazard_detected;
   logic [(1<<REG_ADDR_LEN)-1:0]    pending;
   logic [STALL_CNT_LEN-1:0]        stall_count;

   modport master (
      output id_valid, id_src1, id_src2, id_src2_used, id_wb_en, id_mem_r_en, id_dest,
             stall_clr,
      input  hazard_detected, pending, stall_count
   );

   modport slave (
      input  id_valid, id_src1, id_src2, id_src2_used, id_wb_en, id_mem_r_en, id_dest,
             stall_clr,
      output hazard_detected, pending, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register RAW scoreboard for the ID stage with a saturating stall counter.
// Optional macro HAZARD_FORWARDING_EN: only loads are tracked, with a one-cycle load-use stall.
module hazard_scoreboard #(
   parameter int unsigned REG_ADDR_LEN  = 5,
   parameter int unsigned PIPE_DEPTH    = 3,
   parameter int unsigned STALL_CNT_LEN = 16
) (
   input logic               clk,
   input logic               rst,
   hazard_scoreboard_if.slave bus
);
   localparam int unsigned NumRegs = 1 << REG_ADDR_LEN;

   logic [1:0]               cnt_q [NumRegs];
   logic [1:0]               cnt_d [NumRegs];
   logic [STALL_CNT_LEN-1:0] stall_q, stall_d;
   logic                     hazard;
   logic                     issue;
   logic                     load_en;
   logic [1:0]               load_val;

   // cnt_q[0] is held at zero, so source 0 can never raise a hazard.
   always_comb begin
      hazard = bus.id_valid &
               ((cnt_q[bus.id_src1] != 2'd0) |
                (bus.id_src2_used & (cnt_q[bus.id_src2] != 2'd0)));
      issue  = bus.id_valid & ~hazard;
`ifdef HAZARD_FORWARDING_EN
      load_en  = issue & bus.id_wb_en & bus.id_mem_r_en & (bus.id_dest != '0);
      load_val = 2'd1;
`else
      load_en  = issue & bus.id_wb_en & (bus.id_dest != '0);
      load_val = PIPE_DEPTH[1:0];
`endif
   end

   always_comb begin
      for (int i = 0; i < NumRegs; i++) begin
         cnt_d[i] = 2'd0;
         if (i != 0) begin
            if (load_en && (bus.id_dest == REG_ADDR_LEN'(i))) begin
               cnt_d[i] = load_val;
            end else if (cnt_q[i] != 2'd0) begin
               cnt_d[i] = cnt_q[i] - 2'd1;
            end
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (bus.stall_clr) begin
         stall_d = '0;
      end else if (hazard && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NumRegs; i++) begin
            cnt_q[i] <= 2'd0;
         end
         stall_q <= '0;
      end else begin
         for (int i = 0; i < NumRegs; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stall_q <= stall_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NumRegs; i++) begin
         bus.pending[i] = (cnt_q[i] != 2'd0);
      end
   end

   assign bus.hazard_detected = hazard;
   assign bus.stall_count     = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a reference counter model and expectation queue.
module tb_hazard_scoreboard;
   localparam int unsigned AW = 5;
   localparam int unsigned PD = 3;
   localparam int unsigned SW = 8;
`ifdef HAZARD_FORWARDING_EN
   localparam bit Fwd = 1'b1;
`else
   localparam bit Fwd = 1'b0;
`endif

   typedef struct packed {
      logic          hz;
      logic [31:0]   pend;
      logic [SW-1:0] sc;
   } exp_t;

   logic clk;
   logic rst;
   hazard_scoreboard_if #(.REG_ADDR_LEN(AW), .STALL_CNT_LEN(SW)) bus ();

   hazard_scoreboard #(
      .REG_ADDR_LEN  (AW),
      .PIPE_DEPTH    (PD),
      .STALL_CNT_LEN (SW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_cnt [32];
   int   m_stall;
   logic m_hz;
   exp_t exp_q [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_hz();
      logic h;
      h = bus.id_valid &&
          ((bus.id_src1 != 0 && m_cnt[bus.id_src1] != 0) ||
           (bus.id_src2_used && bus.id_src2 != 0 && m_cnt[bus.id_src2] != 0));
      return h;
   endfunction

   function automatic logic [31:0] model_pend();
      logic [31:0] p;
      for (int i = 0; i < 32; i++) p[i] = (m_cnt[i] != 0);
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_stall = 0;
   endtask

   task automatic model_edge();
      logic do_load;
      int   lv;
      if (!rst) begin
         model_reset();
         return;
      end
      do_load = bus.id_valid && !m_hz && bus.id_wb_en && bus.id_dest != 0 &&
                (!Fwd || bus.id_mem_r_en);
      lv = Fwd ? 1 : PD;
      for (int i = 1; i < 32; i++) begin
         if (do_load && bus.id_dest == 5'(i)) m_cnt[i] = lv;
         else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      end
      if (bus.stall_clr) m_stall = 0;
      else if (m_hz && m_stall < (1 << SW) - 1) m_stall = m_stall + 1;
   endtask

   // One cycle: drive at posedge+1, predict, compare at negedge, advance model at posedge.
   task automatic cyc(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic s2u, input logic wb, input logic mr,
                      input logic [4:0] d, input logic clr);
      exp_t e;
      exp_t got;
      bus.id_valid = v;     bus.id_src1 = s1;    bus.id_src2 = s2;
      bus.id_src2_used = s2u; bus.id_wb_en = wb; bus.id_mem_r_en = mr;
      bus.id_dest = d;      bus.stall_clr = clr;
      #1;
      m_hz = (!rst) ? 1'b0 : model_hz();
      e.hz = m_hz; e.pend = model_pend(); e.sc = SW'(m_stall);
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      check_val("hazard", {31'd0, bus.hazard_detected}, {31'd0, got.hz});
      check_val("pending", bus.pending, got.pend);
      check_val("stall_count", {24'd0, bus.stall_count}, {24'd0, got.sc});
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      model_reset();
      m_hz = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset held with random inputs.
      for (int i = 0; i < 4; i++) begin
         cyc(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom), 1'($urandom));
      end
      check_val("reset_pending", bus.pending, 32'd0);
      check_val("reset_stall", {24'd0, bus.stall_count}, 32'd0);
      rst = 1'b1;
      idle(1);

      // ALU RAW: ADD R1 then ADD R2,R1,R3 held in ID.
      cyc(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0);
      idle(1);
      check_val("alu_raw_stalls", {24'd0, bus.stall_count}, Fwd ? 32'd0 : 32'd3);
      idle(3);
      cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);

      // Load-use: LD R4 then ADD R5,R4,R4.
      cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
      check_val("ld_pending4", {31'd0, bus.pending[4]}, 32'd1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0);
      idle(1);
      check_val("load_use_stalls", {24'd0, bus.stall_count}, Fwd ? 32'd1 : 32'd3);
      idle(3);
      cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);

      // Writes to R0 are never tracked.
      cyc(1'b1, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
      check_val("r0_pending", bus.pending, 32'd0);
      cyc(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
      idle(3);

      // R6 pending: unused src2 is ignored, used src2 (ST) stalls.
      cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0);
      cyc(1'b1, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(3);

      // Re-issue to R7 when its counter is at 1 reloads it.
      cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0);
      idle(2);
      cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(3);

      // Reset asserted in the middle of a stall.
      cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
      bus.id_valid = 1'b1; bus.id_src1 = 5'd8; bus.id_src2 = 5'd0; bus.id_src2_used = 1'b0;
      bus.id_wb_en = 1'b0; bus.id_mem_r_en = 1'b0; bus.id_dest = 5'd0; bus.stall_clr = 1'b0;
      #2;
      check_val("pre_reset_hazard", {31'd0, bus.hazard_detected}, 32'd1);
      rst = 1'b0;
      #1;
      check_val("mid_reset_hazard", {31'd0, bus.hazard_detected}, 32'd0);
      check_val("mid_reset_pending", bus.pending, 32'd0);
      check_val("mid_reset_stall", {24'd0, bus.stall_count}, 32'd0);
      model_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
      cyc(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(1);

      // Saturation: a load that reads and rewrites R9, held in ID.
      for (int i = 0; i < 600; i++) cyc(1'b1, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
      check_val("stall_saturated", {24'd0, bus.stall_count}, 32'hFF);
      begin
         int guard = 0;
         bus.id_valid = 1'b1; bus.id_src1 = 5'd9; #1;
         while (!model_hz() && guard < 8) begin
            cyc(1'b1, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
            guard++;
         end
         check_val("found_stall", {31'd0, model_hz()}, 32'd1);
      end
      cyc(1'b1, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1);
      check_val("stall_clr", {24'd0, bus.stall_count}, 32'd0);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
